// File: rtl/seg_scan_driver_pkg.sv
// Shared constants for the multiplexed 7-segment scan driver.
// Segment patterns are active-high {g,f,e,d,c,b,a}; the board-facing outputs are inverted.
package seg_scan_driver_pkg;

  localparam logic [7:0] SEG_BLANK = 8'hFF;
  localparam logic [3:0] AN_BLANK  = 4'hF;
  localparam logic [6:0] SEG_OFF   = 7'h7F;

  localparam logic ST_BLANK = 1'b0;
  localparam logic ST_DRIVE = 1'b1;

  localparam logic [6:0] SEG7_MAP [16] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
    7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
  };

endpackage

// File: rtl/seg_scan_driver_seg7_decode.sv
// Combinational hex digit to active-high 7-segment pattern {g..a}.
module seg7_decode
  import seg_scan_driver_pkg::*;
(
  input  logic [3:0] dig_i,
  output logic [6:0] seg_o
);

  assign seg_o = SEG7_MAP[dig_i];

endmodule

// File: rtl/seg_scan_driver.sv
// 4-digit multiplexed 7-segment scanner with frame-aligned double buffering,
// per-slot dead-time and optional leading-zero blanking; all outputs registered.
module seg_scan_driver
  import seg_scan_driver_pkg::*;
#(
  parameter int SCAN_DIV  = 50000,
  parameter int BLANK_CYC = 500
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        dispen,
  input  logic        upd,
  input  logic [15:0] digits,
  input  logic [3:0]  dp,
  input  logic        lzb,
  output logic [3:0]  an,
  output logic [7:0]  seg,
  output logic        frame
);

  localparam int CNT_W = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST   = CNT_W'(SCAN_DIV - 1);
  localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_CYC - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0]       idx_q, idx_d;
  logic             st_q, st_d;
  logic [15:0]      shd_dig_q, shd_dig_d;
  logic [3:0]       shd_dp_q, shd_dp_d;
  logic             pend_q, pend_d;
  logic [15:0]      act_dig_q, act_dig_d;
  logic [3:0]       act_dp_q, act_dp_d;
  logic [3:0]       an_q, an_d;
  logic [7:0]       seg_q, seg_d;
  logic             frame_q, frame_d;

  logic             slot_end;
  logic             wrap;
  logic [3:0]       cur_dig;
  logic [6:0]       dec_seg;
  logic [3:0]       lz_run;
  logic             lz_blank;

  assign slot_end = (cnt_q == CNT_LAST);
  assign wrap     = slot_end && (idx_q == 2'd3);
  assign cur_dig  = act_dig_q[idx_q*4 +: 4];

  seg7_decode u_dec (
    .dig_i (cur_dig),
    .seg_o (dec_seg)
  );

  // lz_run[i]: active digits i..3 are all zero
  always_comb begin
    lz_run    = '0;
    lz_run[3] = (act_dig_q[15:12] == 4'd0);
    for (int i = 2; i >= 0; i--) begin
      lz_run[i] = lz_run[i+1] && (act_dig_q[i*4 +: 4] == 4'd0);
    end
    lz_blank = lzb && (idx_q != 2'd0) && lz_run[idx_q];
  end

  always_comb begin
    cnt_d = slot_end ? '0 : cnt_q + 1'b1;
    idx_d = slot_end ? idx_q + 2'd1 : idx_q;

    st_d = st_q;
    if (slot_end) begin
      st_d = ST_BLANK;
    end else if (cnt_q == BLANK_LAST) begin
      st_d = ST_DRIVE;
    end

    shd_dig_d = shd_dig_q;
    shd_dp_d  = shd_dp_q;
    pend_d    = pend_q;
    act_dig_d = act_dig_q;
    act_dp_d  = act_dp_q;
    if (upd) begin
      shd_dig_d = digits;
      shd_dp_d  = dp;
      pend_d    = 1'b1;
    end
    // An update landing on the wrap cycle bypasses the shadow so it is not lost
    if (wrap) begin
      if (upd) begin
        act_dig_d = digits;
        act_dp_d  = dp;
        pend_d    = 1'b0;
      end else if (pend_q) begin
        act_dig_d = shd_dig_q;
        act_dp_d  = shd_dp_q;
        pend_d    = 1'b0;
      end
    end

    an_d  = AN_BLANK;
    seg_d = SEG_BLANK;
    if (dispen && (st_q == ST_DRIVE)) begin
      an_d  = ~(4'b0001 << idx_q);
      seg_d = {~act_dp_q[idx_q], lz_blank ? SEG_OFF : ~dec_seg};
    end

    frame_d = wrap;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q     <= '0;
      idx_q     <= 2'd0;
      st_q      <= ST_BLANK;
      shd_dig_q <= '0;
      shd_dp_q  <= '0;
      pend_q    <= 1'b0;
      act_dig_q <= '0;
      act_dp_q  <= '0;
      an_q      <= AN_BLANK;
      seg_q     <= SEG_BLANK;
      frame_q   <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      idx_q     <= idx_d;
      st_q      <= st_d;
      shd_dig_q <= shd_dig_d;
      shd_dp_q  <= shd_dp_d;
      pend_q    <= pend_d;
      act_dig_q <= act_dig_d;
      act_dp_q  <= act_dp_d;
      an_q      <= an_d;
      seg_q     <= seg_d;
      frame_q   <= frame_d;
    end
  end

  assign an    = an_q;
  assign seg   = seg_q;
  assign frame = frame_q;

endmodule

// File: tb/tb_seg_scan_driver.sv
// Scoreboard bench: expected outputs are queued per clock edge, a negedge monitor compares.
module tb_seg_scan_driver;

  logic        clk;
  logic        rst;
  logic        dispen;
  logic        upd;
  logic [15:0] digits;
  logic [3:0]  dp;
  logic        lzb;
  logic [3:0]  an;
  logic [7:0]  seg;
  logic        frame;

  seg_scan_driver #(.SCAN_DIV(4), .BLANK_CYC(1)) dut (
    .clk    (clk),
    .rst    (rst),
    .dispen (dispen),
    .upd    (upd),
    .digits (digits),
    .dp     (dp),
    .lzb    (lzb),
    .an     (an),
    .seg    (seg),
    .frame  (frame)
  );

  typedef struct packed {
    int         tag;
    logic [3:0] an;
    logic [7:0] seg;
    logic       frame;
  } exp_t;

  exp_t  exp_q[$];
  string nm_q[$];
  int    e;
  int    n_chk;
  int    n_err;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic push(input int tag, input logic [3:0] a, input logic [7:0] s,
                      input logic f, input string nm);
    exp_t x;
    x.tag = tag; x.an = a; x.seg = s; x.frame = f;
    exp_q.push_back(x);
    nm_q.push_back(nm);
  endtask

  // One frame = 16 edges: 4 slots of {blank, drive, drive, drive}; frame pulse on the last edge
  task automatic exp_frame(input int k, input logic en,
                           input logic [7:0] s0, input logic [7:0] s1,
                           input logic [7:0] s2, input logic [7:0] s3, input string nm);
    logic [7:0] sv [4];
    sv[0] = s0; sv[1] = s1; sv[2] = s2; sv[3] = s3;
    for (int n = 1; n <= 16; n++) begin
      int slot;
      int c;
      slot = (n - 1) / 4;
      c    = (n - 1) % 4;
      if (c == 0 || !en) push(16*k + n, 4'hF, 8'hFF, n == 16, nm);
      else               push(16*k + n, ~(4'b0001 << slot), sv[slot], n == 16, nm);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    e++;
    #1;
  endtask

  task automatic goto(input int t);
    while (e < t) tick();
  endtask

  task automatic do_upd(input logic [15:0] d, input logic [3:0] p);
    upd = 1'b1; digits = d; dp = p;
    tick();
    upd = 1'b0;
  endtask

  task automatic drain();
    for (int i = 0; i < 50 && exp_q.size() > 0; i++) @(negedge clk);
    if (exp_q.size() > 0) begin
      n_chk++;
      n_err++;
      $display("FAIL drain: %0d checks left, want 0", exp_q.size());
    end
  endtask

  always @(negedge clk) begin
    while (exp_q.size() > 0 && exp_q[0].tag <= e) begin
      exp_t  x;
      string nm;
      x  = exp_q.pop_front();
      nm = nm_q.pop_front();
      n_chk++;
      if (x.tag != e) begin
        n_err++;
        $display("FAIL %s: edge %0d not observed (now at %0d)", nm, x.tag, e);
      end else if (an !== x.an || seg !== x.seg || frame !== x.frame) begin
        n_err++;
        $display("FAIL %s edge %0d: got an=%h seg=%h frame=%b, want an=%h seg=%h frame=%b",
                 nm, e, an, seg, frame, x.an, x.seg, x.frame);
      end
    end
  end

  initial begin
    #50000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b0; dispen = 1'b1; upd = 1'b0; digits = '0; dp = '0; lzb = 1'b0;
    e = 0; n_chk = 0; n_err = 0;

    push(0, 4'hF, 8'hFF, 1'b0, "in_reset");
    exp_frame(0, 1'b1, 8'hC0, 8'hC0, 8'hC0, 8'hC0, "post_reset_zero");
    exp_frame(1, 1'b1, 8'hC0, 8'hC0, 8'hC0, 8'hC0, "pending_held");
    exp_frame(2, 1'b1, 8'h99, 8'hB0, 8'hA4, 8'hF9, "show_1234");
    exp_frame(3, 1'b1, 8'h90, 8'h90, 8'h90, 8'h90, "show_9999");
    exp_frame(4, 1'b1, 8'h80, 8'hF8, 8'h82, 8'h92, "wrap_coincident_5678");
    exp_frame(5, 1'b1, 8'hC0, 8'h92, 8'hFF, 8'hFF, "lzb_0050");
    exp_frame(6, 1'b1, 8'hC0, 8'h92, 8'h7F, 8'hFF, "lzb_0050_dp");
    exp_frame(7, 1'b0, 8'hFF, 8'hFF, 8'hFF, 8'hFF, "dispen_off");
    exp_frame(8, 1'b1, 8'hC0, 8'h92, 8'h40, 8'hC0, "no_lzb_0050_dp");
    push(150, 4'hD, 8'h92, 1'b0, "pre_async_reset");
    push(151, 4'hF, 8'hFF, 1'b0, "async_reset");

    repeat (3) @(posedge clk);
    #1 rst = 1'b1;

    goto(20);
    do_upd(16'h1234, 4'b0000);       // sampled edge 21, shown from frame 2
    goto(39);
    do_upd(16'h9999, 4'b0000);       // sampled edge 40, mid frame 2
    goto(57);
    do_upd(16'hAAAA, 4'b0000);       // overridden by the wrap-cycle update
    goto(63);
    do_upd(16'h5678, 4'b0000);       // sampled on wrap edge 64
    goto(69);
    lzb = 1'b1;
    do_upd(16'h0050, 4'b0000);
    goto(89);
    do_upd(16'h0050, 4'b0100);
    goto(112);
    dispen = 1'b0;
    goto(128);
    dispen = 1'b1;
    lzb = 1'b0;
    goto(147);
    do_upd(16'h1111, 4'b0000);       // left pending, must be dropped by reset
    goto(151);
    #2 rst = 1'b0;
    drain();

    repeat (3) @(posedge clk);
    e = 0;
    exp_frame(0, 1'b1, 8'hC0, 8'hC0, 8'hC0, 8'hC0, "rerun_zero");
    exp_frame(1, 1'b1, 8'hC0, 8'hC0, 8'hC0, 8'hC0, "pending_discarded");
    #1 rst = 1'b1;
    goto(32);
    drain();

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/seg_scan_driver.md
# seg_scan_driver

Display back end for the stopwatch datapath: takes the four BCD/hex digits and the decimal-point mask that the counter core produces, and drives a 4-digit multiplexed 7-segment display on `an`/`seg`. New values are double-buffered so the display only changes at frame boundaries, which prevents torn or ghosted digits. A short dead-time at each digit switch suppresses ghosting, and optional leading-zero blanking is provided.

## Interface
- `SCAN_DIV`, default 50000: clock cycles per digit slot; must be ≥ 2.
- `BLANK_CYC`, default 500: dead-time cycles at the start of each slot; must satisfy 0 < `BLANK_CYC` < `SCAN_DIV`.
- `clk`  in  1  system clock; all state updates on the rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `dispen`  in  1  display enable; when low, all outputs read as blank.
- `upd`  in  1  one-cycle strobe that captures `digits`/`dp` into the shadow register.
- `digits`  in  16  four 4-bit codes; `[3:0]` is the rightmost digit (slot 0).
- `dp`  in  4  decimal-point enables, one bit per slot.
- `lzb`  in  1  leading-zero blanking enable.
- `an`  out  4  digit anodes, active-low; `an[i]` selects slot i.
- `seg`  out  8  segments, active-low, ordered {dp,g,f,e,d,c,b,a}.
- `frame`  out  1  one-cycle pulse on each slot 3 → 0 wrap.

## Operation
- Reset values: `an`=4'hF, `seg`=8'hFF, `frame`=0; slot counter `cnt`=0; slot index `idx`=0; shadow=0; active=0.
- Slot timing:
  - `cnt` counts 0..`SCAN_DIV`-1.
  - At `cnt`=`SCAN_DIV`-1, `cnt` returns to 0 and `idx` increments modulo 4.
- Per-slot two-state FSM:
  - BLANK while `cnt` < `BLANK_CYC`.
  - DRIVE otherwise.
  - BLANK→DRIVE when `cnt` = `BLANK_CYC`-1; DRIVE→BLANK at the slot end.
- BLANK output: `an`=4'hF, `seg`=8'hFF.
- DRIVE output: `an` = ~(1<<`idx`); `seg` = {~dp[idx], ~decode(active digit idx)}.
- Decode map (active-high {g..a}, before inversion): 0=3F, 1=06, 2=5B, 3=4F, 4=66, 5=6D, 6=7D, 7=07, 8=7F, 9=6F, A=77, b=7C, C=39, d=5E, E=79, F=71.
- Leading-zero blanking: slot i ≥ 1 is blanked (`seg` segment bits all 1) when `lzb`=1 and every active digit j in i..3 is 0.
  - Slot 0 is never blanked.
  - The `dp` bit is still honoured in a blanked slot.
  - The anode still asserts for a blanked slot.
- Buffering:
  - `upd` writes `digits`/`dp` into the shadow register and sets `pending`.
  - At a wrap, if `pending`=1, shadow is copied to active and `pending` clears.
  - If `upd` coincides with the wrap cycle, active takes the incoming `digits`/`dp` directly and `pending` ends at 0.
- `dispen`=0: outputs are forced blank. `cnt`, `idx`, buffering and `frame` keep running.
- `rst` asserted mid-frame: immediate asynchronous return to reset values. Any pending update is discarded.

## Timing
- `an`, `seg` and `frame` are registered: each reflects `idx`/`cnt`/active as sampled on the previous edge (1-cycle latency).
- After `rst` is released, the first edge produces a blank output. `an` first reads 4'b1110 after `BLANK_CYC`+1 edges.
- `frame` is high for exactly the one cycle after the edge on which `idx` wraps 3→0. The new active data is visible from the first DRIVE cycle of slot 0.
- Frame period = 4·`SCAN_DIV` cycles. No handshake: `upd` is fire-and-forget, and the last `upd` before a wrap wins.

## Structure
- Shared package holds:
  - the 16-entry segment decode constant;
  - the blank constants: `seg` 8'hFF, `an` 4'hF.
- One natural sub-module: `seg7_decode` (combinational 4-bit → 7-bit active-high).
- Counter, FSM, buffering and output registers stay in `seg_scan_driver`.

## Test plan
All scenarios use `SCAN_DIV`=4, `BLANK_CYC`=1.
- Reset hold/release, with `upd` never asserted: `an`=F and `seg`=FF during reset. After release, `an` sequence per slot is F,E,E,E, F,D,D,D, …, with `seg`=C0 in DRIVE cycles.
- `upd` with `digits`=16'h1234, `dp`=0, then wait for a `frame` pulse: next frame shows
  - slot 0: `an`=E, `seg`=99
  - slot 1: `an`=D, `seg`=B0
  - slot 2: `an`=B, `seg`=A4
  - slot 3: `an`=7, `seg`=F9
- `lzb`=1, `digits`=16'h0050: slots 3 and 2 read `seg`=FF with their anodes asserted; slot 1 reads 92; slot 0 reads C0. With `dp`=4'b0100, slot 2 reads 7F.
- Mid-frame `upd` of 16'h9999 while 16'h1234 is displayed: remaining slots of the current frame keep the old values. After the wrap, every slot reads `seg`=90.
- `upd` coincident with the wrap cycle: the new value appears in slot 0 of the immediately following frame.
- `dispen`=0 for one full frame: `an`=F and `seg`=FF throughout, while `frame` still pulses every 16 cycles.
- `rst` asserted mid-slot: `an`/`seg` go to F/FF without waiting for a clock edge.
